// File: rtl/ysyx_22041412_mdu.sv
// Iterative radix-2 RV64M multiply/divide unit with valid/ready handshakes on both sides.
// Optional YSYX_22041412_MDU_EARLY_OUT_EN skips CALC for divide-by-zero, overflow and zero MUL.
module ysyx_22041412_mdu #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic [2:0]      func3,
    input  logic            word,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic sg);
        logic [XLEN-1:0] t;
        t       = {XLEN{sg & v[31]}};
        t[31:0] = v;
        return t;
    endfunction

    function automatic logic [XLEN-1:0] finalize(input logic [XLEN-1:0] raw, input logic w,
                                                 input logic bad);
        if (bad) return '0;
        if (w) return ext32(raw[31:0], 1'b1);
        return raw;
    endfunction

    logic [1:0]        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        op_q;
    logic              word_q;
    logic              bad_q;
    logic              neg_q;
    logic              dz_q;
    logic [2*XLEN-1:0] acc_q;
    logic [2*XLEN-1:0] mcand_q;
    logic [XLEN-1:0]   b_q;
    logic [XLEN-1:0]   quo_q;
    logic [XLEN-1:0]   rem_q;
    logic [XLEN-1:0]   result_q;

    logic              accept;
    logic              sg1;
    logic              sg2;
    logic              neg1;
    logic              neg2;
    logic              neg_in;
    logic              bad_in;
    logic              dz_in;
    logic [XLEN-1:0]   op1_ext;
    logic [XLEN-1:0]   op2_ext;
    logic [XLEN-1:0]   mag1;
    logic [XLEN-1:0]   mag2;
    logic [XLEN-1:0]   quo_init;
    logic              eo_hit;
    logic [XLEN-1:0]   eo_result;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign accept    = in_valid && in_ready && !flush;

    // Operand preparation: extension for W forms, then sign/magnitude split.
    always_comb begin
        sg1     = func3[2] ? !func3[0] : (func3[1:0] != 2'b11);
        sg2     = func3[2] ? !func3[0] : !func3[1];
        bad_in  = word && ((XLEN != 64) || (!func3[2] && (func3[1:0] != 2'b00)));
        op1_ext = src1;
        op2_ext = src2;
        if (word) begin
            op1_ext = ext32(src1[31:0], sg1);
            op2_ext = ext32(src2[31:0], sg2);
        end
        neg1     = sg1 & op1_ext[XLEN-1];
        neg2     = sg2 & op2_ext[XLEN-1];
        mag1     = neg1 ? -op1_ext : op1_ext;
        mag2     = neg2 ? -op2_ext : op2_ext;
        // Remainder follows the dividend; product and quotient follow both operands.
        neg_in   = (func3[2] && func3[1]) ? neg1 : (neg1 ^ neg2);
        // Word dividends are left-aligned so the next dividend bit is always the MSB.
        quo_init = word ? (mag1 << (XLEN - 32)) : mag1;
        dz_in    = func3[2] && (op2_ext == '0);
    end

`ifdef YSYX_22041412_MDU_EARLY_OUT_EN
    logic            eo_mul_zero;
    logic            eo_ovf;
    logic [XLEN-1:0] eo_raw;
    logic [XLEN-1:0] min_n;

    always_comb begin
        min_n       = word ? ext32(32'h8000_0000, 1'b1) : {1'b1, {(XLEN-1){1'b0}}};
        eo_mul_zero = !func3[2] && !bad_in && ((op1_ext == '0) || (op2_ext == '0));
        eo_ovf      = func3[2] && !func3[0] && (op1_ext == min_n) && (op2_ext == '1);
        eo_hit      = eo_mul_zero || dz_in || eo_ovf;
        if (dz_in) begin
            eo_raw = func3[1] ? op1_ext : '1;
        end else if (eo_ovf) begin
            eo_raw = func3[1] ? '0 : op1_ext;
        end else begin
            eo_raw = '0;
        end
        eo_result = finalize(eo_raw, word, bad_in);
    end
`else
    assign eo_hit    = 1'b0;
    assign eo_result = '0;
`endif

    logic [2*XLEN-1:0] acc_nxt;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN:0]     shifted;
    logic [XLEN:0]     diff;
    logic [XLEN-1:0]   quo_nxt;
    logic [XLEN-1:0]   rem_nxt;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   calc_raw;
    logic [XLEN-1:0]   calc_result;
    logic              last;

    // One shift-add and one restoring shift-subtract step; the op decides which is kept.
    always_comb begin
        acc_nxt  = acc_q + (b_q[0] ? mcand_q : '0);
        shifted  = {rem_q, quo_q[XLEN-1]};
        diff     = shifted - {1'b0, b_q};
        quo_nxt  = {quo_q[XLEN-2:0], ~diff[XLEN]};
        rem_nxt  = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
        prod_fix = neg_q ? -acc_nxt : acc_nxt;
        quo_fix  = neg_q ? -quo_nxt : quo_nxt;
        rem_fix  = neg_q ? -rem_nxt : rem_nxt;
        case (op_q)
            3'b000:                 calc_raw = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: calc_raw = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         calc_raw = dz_q ? '1 : quo_fix;
            default:                calc_raw = rem_fix;
        endcase
        calc_result = finalize(calc_raw, word_q, bad_q);
        last        = (cnt_q == (word_q ? CNT_W'(31) : CNT_W'(XLEN - 1)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            word_q   <= 1'b0;
            bad_q    <= 1'b0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            b_q      <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
        end else if (flush) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q    <= func3;
                        word_q  <= word;
                        bad_q   <= bad_in;
                        neg_q   <= neg_in;
                        dz_q    <= dz_in;
                        acc_q   <= '0;
                        mcand_q <= {{XLEN{1'b0}}, mag1};
                        b_q     <= mag2;
                        quo_q   <= quo_init;
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        if (eo_hit) begin
                            state_q  <= DONE;
                            result_q <= eo_result;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (!op_q[2]) begin
                        acc_q   <= acc_nxt;
                        mcand_q <= mcand_q << 1;
                        b_q     <= b_q >> 1;
                    end else begin
                        quo_q <= quo_nxt;
                        rem_q <= rem_nxt;
                    end
                    if (last) begin
                        state_q  <= DONE;
                        cnt_q    <= '0;
                        result_q <= calc_result;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ysyx_22041412_mdu.md
Name: ysyx_22041412_mdu

Overview:
- Parametrised iterative multiply/divide unit that executes RV64M operations (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and the W forms).
- Sits beside the single-cycle integer ALU in the EXU. Decode steers M-extension ops (R-type/RV64_R opcode with func7=0000001) here instead of to the ALU.
- Multi-cycle: one radix-2 step per cycle, with valid/ready handshakes on both the input and output sides, and a flush input for pipeline redirects.

Parameters:
- XLEN, 64, operand/result width; legal values 32 or 64. W ops are only legal when XLEN=64.
- CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- flush  input  1  abort any in-flight op and drop the held result
- in_valid  input  1  operation request
- in_ready  output  1  unit can accept a request (state IDLE)
- src1  input  XLEN  rs1 value
- src2  input  XLEN  rs2 value
- func3  input  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- word  input  1  W variant (RV64_R opcode); only MUL, DIV, DIVU, REM, REMU are legal with word=1
- out_valid  output  1  result available
- out_ready  input  1  consumer takes the result
- result  output  XLEN  result value

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, result=0, all internal registers 0.
- Request accepted when in_valid && in_ready && !flush. On acceptance, latch the op and operands.
- Operand preparation:
  - word=1: use src[31:0], sign- or zero-extended per op.
  - Signed operands are converted to magnitudes; the result sign is recorded.
  - MULHSU: src1 signed, src2 unsigned.
- States:
  - IDLE: in_ready=1. On acceptance go to CALC, counter=0.
  - CALC: in_ready=0. Perform one shift-add (mul) or restoring shift-subtract (div) step per cycle. When the counter reaches N-1 (N=32 for word ops, else XLEN), go to DONE.
  - DONE: out_valid=1, result stable. On out_ready go to IDLE. out_valid falls in the same cycle in_ready rises; no back-to-back overlap.
- Latency: acceptance cycle, then N CALC cycles, then out_valid on the next edge. Total = N+1 cycles from acceptance to out_valid (65 for 64-bit, 33 for word ops).
- Result selection:
  - MUL: low XLEN bits of the 2·XLEN product.
  - MULH/MULHSU/MULHU: high XLEN bits.
  - DIV/DIVU: quotient. REM/REMU: remainder.
  - Sign fix-up: apply the recorded sign with a two's-complement negate in the final CALC cycle. Quotient sign = sign1^sign2; remainder takes the dividend's sign.
  - word=1: result = sign-extend of the 32-bit result bit 31 to XLEN.
- Boundary cases (RISC-V spec values):
  - Divide by zero: quotient = all ones (DIVU) or -1 (DIV); remainder = dividend, sign-extended for W forms.
  - Signed overflow (MIN / -1): quotient = MIN, remainder = 0.
  - These use the normal N-cycle latency unless the optional feature below is enabled.
- flush:
  - Asserted in any state: next state IDLE, out_valid=0, the held result is discarded, counter cleared.
  - flush together with in_valid in IDLE: the request is not accepted.
  - flush while DONE with out_ready=1: treated as a flush; the consumer must ignore that cycle.
- Reset mid-op: asynchronous return to the reset values regardless of state.
- Undefined func3/word combinations (word=1 with MULH*): result=0, normal latency, no hang.

Optional Feature:
- Macro: YSYX_22041412_MDU_EARLY_OUT_EN
- Defined: divide by zero, signed overflow, or any MUL* with a zero operand skips CALC. The unit goes IDLE→DONE, with out_valid on the edge after acceptance (latency 1) and the same result values as the full path.
- Undefined: all ops take the full N+1 cycles and no early-out comparators are instantiated.

Test Plan:
- MUL, src1=0xFFFF_FFFF_FFFF_FFFF (-1), src2=3 → result 0xFFFF_FFFF_FFFF_FFFD; out_valid exactly 65 cycles after acceptance.
- MULHU, src1=src2=0xFFFF_FFFF_FFFF_FFFF → result 0xFFFF_FFFF_FFFF_FFFE. MULH with the same operands → result 0.
- DIV, src1=-7, src2=2 → result -3 (0xFFFF_FFFF_FFFF_FFFD). REM with the same operands → -1. DIVU, src2=0 → 0xFFFF_FFFF_FFFF_FFFF. REM, src2=0 → src1.
- DIV, src1=0x8000_0000_0000_0000, src2=-1 → result 0x8000_0000_0000_0000. REM with the same operands → 0.
- DIVW, word=1, src1=0x1_8000_0000, src2=0xFFFF_FFFF → result 0xFFFF_FFFF_8000_0000; out_valid after 33 cycles.
- Accept DIV, then assert flush at CALC cycle 10 → in_ready=1 next cycle and out_valid never rises. Hold out_ready=0 in DONE for 5 cycles → result stable and in_ready=0 throughout. With YSYX_22041412_MDU_EARLY_OUT_EN, DIV by 0 → out_valid 1 cycle after acceptance.
